wb_rf_write_sched: RTL and testbench

//  Sequencer for the single GPR write port behind the dual-issue writeback stage.

---
 rtl/wb_rf_write_sched_pkg.sv | 49 ++++
 rtl/wb_rf_write_sched.sv | 204 ++++++++++++++++++++
 tb/tb_wb_rf_write_sched.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_rf_write_sched_pkg.sv
// Shared definitions for the writeback RF write sequencer: FSM encoding,
// forward-bus layout and the helper that decides whether a write is real.
package wb_rf_write_sched_pkg;

    // Sequencer states (2-bit encoding)
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_S1   = 2'd1,
        ST_S2   = 2'd2,
        ST_BUB  = 2'd3
    } ws_state_e;

    // Forward bus width and field offsets, shared with mem_stage's bus layout
    localparam int WS_SCHED_FWD_WD   = 77;
    localparam int FWD_I2_WDATA_LSB  = 0;
    localparam int FWD_I2_DEST_LSB   = 32;
    localparam int FWD_I2_PEND_BIT   = 37;
    localparam int FWD_I1_WDATA_LSB  = 38;
    localparam int FWD_I1_DEST_LSB   = 70;
    localparam int FWD_I1_PEND_BIT   = 75;
    localparam int FWD_BUSY_BIT      = 76;

    // A write is effective unless it targets $0 while $0 writes are dropped
    function automatic logic eff_write(input logic we, input logic [4:0] dest,
                                       input logic drop_r0);
        return we & ~(drop_r0 & (dest == 5'd0));
    endfunction

    // Assemble the forward bus; dest/data are zeroed when not pending
    function automatic logic [WS_SCHED_FWD_WD-1:0] pack_fwd(
        input logic        busy,
        input logic        i1_pend,
        input logic [4:0]  i1_dest,
        input logic [31:0] i1_wdata,
        input logic        i2_pend,
        input logic [4:0]  i2_dest,
        input logic [31:0] i2_wdata);
        logic [4:0]  d1;
        logic [31:0] x1;
        logic [4:0]  d2;
        logic [31:0] x2;
        d1 = i1_pend ? i1_dest  : 5'd0;
        x1 = i1_pend ? i1_wdata : 32'd0;
        d2 = i2_pend ? i2_dest  : 5'd0;
        x2 = i2_pend ? i2_wdata : 32'd0;
        return {busy, i1_pend, d1, x1, i2_pend, d2, x2};
    endfunction

endpackage

// File: rtl/wb_rf_write_sched.sv
// Single GPR write-port sequencer behind the dual-issue writeback stage.
// Accepts one retired bundle per handshake, emits its writes in program
// order (inst1 then inst2), mirrors them on the debug trace port and
// exposes not-yet-retired results on the forward bus. All outputs are
// registered: they are computed from the next state and next buffer.
module wb_rf_write_sched
    import wb_rf_write_sched_pkg::*;
#(
    parameter bit DROP_R0 = 1'b1,
    parameter int PC_W    = 32
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic                       in_i1_we,
    input  logic [4:0]                 in_i1_dest,
    input  logic [31:0]                in_i1_wdata,
    input  logic [PC_W-1:0]            in_i1_pc,
    input  logic                       in_i2_valid,
    input  logic                       in_i2_we,
    input  logic [4:0]                 in_i2_dest,
    input  logic [31:0]                in_i2_wdata,
    input  logic [PC_W-1:0]            in_i2_pc,
    output logic                       rf_we,
    output logic [4:0]                 rf_waddr,
    output logic [31:0]                rf_wdata,
    output logic [WS_SCHED_FWD_WD-1:0] fwd_bus,
    output logic [31:0]                debug_wb_pc,
    output logic [3:0]                 debug_wb_rf_wen,
    output logic [4:0]                 debug_wb_rf_wnum,
    output logic [31:0]                debug_wb_rf_wdata
);

    ws_state_e         state_r;
    ws_state_e         state_nxt_s;

    // Bundle buffer; w1/w2 hold the effective (post $0-drop) write flags
    logic              buf_w1_r;
    logic [4:0]        buf_i1_dest_r;
    logic [31:0]       buf_i1_wdata_r;
    logic [PC_W-1:0]   buf_i1_pc_r;
    logic              buf_w2_r;
    logic [4:0]        buf_i2_dest_r;
    logic [31:0]       buf_i2_wdata_r;
    logic [PC_W-1:0]   buf_i2_pc_r;

    logic              buf_w1_nxt_s;
    logic [4:0]        buf_i1_dest_nxt_s;
    logic [31:0]       buf_i1_wdata_nxt_s;
    logic [PC_W-1:0]   buf_i1_pc_nxt_s;
    logic              buf_w2_nxt_s;
    logic [4:0]        buf_i2_dest_nxt_s;
    logic [31:0]       buf_i2_wdata_nxt_s;
    logic [PC_W-1:0]   buf_i2_pc_nxt_s;

    logic              last_cycle_s;
    logic              ready_s;
    logic              accept_s;
    logic              new_w1_s;
    logic              new_w2_s;

    logic              we_nxt_s;
    logic [4:0]        waddr_nxt_s;
    logic [31:0]       wdata_nxt_s;
    logic [31:0]       pc_nxt_s;
    logic              ready_nxt_s;
    logic [WS_SCHED_FWD_WD-1:0] fwd_nxt_s;

    // Handshake, next-state and buffer-load decisions for this cycle
    always_comb begin
        state_nxt_s        = state_r;
        buf_w1_nxt_s       = buf_w1_r;
        buf_i1_dest_nxt_s  = buf_i1_dest_r;
        buf_i1_wdata_nxt_s = buf_i1_wdata_r;
        buf_i1_pc_nxt_s    = buf_i1_pc_r;
        buf_w2_nxt_s       = buf_w2_r;
        buf_i2_dest_nxt_s  = buf_i2_dest_r;
        buf_i2_wdata_nxt_s = buf_i2_wdata_r;
        buf_i2_pc_nxt_s    = buf_i2_pc_r;

        // The bundle finishes this cycle unless S1 still owes inst2's write
        last_cycle_s = (state_r == ST_S2) | (state_r == ST_BUB) |
                       ((state_r == ST_S1) & ~buf_w2_r);
        ready_s      = (state_r == ST_IDLE) | last_cycle_s;
        accept_s     = in_valid & ready_s;
        new_w1_s     = eff_write(in_i1_we, in_i1_dest, DROP_R0);
        new_w2_s     = eff_write(in_i2_valid & in_i2_we, in_i2_dest, DROP_R0);

        if (accept_s) begin
            buf_w1_nxt_s       = new_w1_s;
            buf_i1_dest_nxt_s  = in_i1_dest;
            buf_i1_wdata_nxt_s = in_i1_wdata;
            buf_i1_pc_nxt_s    = in_i1_pc;
            buf_w2_nxt_s       = new_w2_s;
            buf_i2_dest_nxt_s  = in_i2_dest;
            buf_i2_wdata_nxt_s = in_i2_wdata;
            buf_i2_pc_nxt_s    = in_i2_pc;
            if (new_w1_s) begin
                state_nxt_s = ST_S1;
            end else if (new_w2_s) begin
                state_nxt_s = ST_S2;
            end else begin
                state_nxt_s = ST_BUB;
            end
        end else if (ready_s) begin
            state_nxt_s = ST_IDLE;
        end else begin
            // Only S1 with a pending inst2 write is not ready
            state_nxt_s = ST_S2;
        end
    end

    // Output values for the coming cycle, derived from next state and buffer
    always_comb begin
        we_nxt_s    = 1'b0;
        waddr_nxt_s = 5'd0;
        wdata_nxt_s = 32'd0;
        pc_nxt_s    = 32'd0;
        case (state_nxt_s)
            ST_S1: begin
                we_nxt_s    = 1'b1;
                waddr_nxt_s = buf_i1_dest_nxt_s;
                wdata_nxt_s = buf_i1_wdata_nxt_s;
                pc_nxt_s    = 32'(buf_i1_pc_nxt_s);
            end
            ST_S2: begin
                we_nxt_s    = 1'b1;
                waddr_nxt_s = buf_i2_dest_nxt_s;
                wdata_nxt_s = buf_i2_wdata_nxt_s;
                pc_nxt_s    = 32'(buf_i2_pc_nxt_s);
            end
            default: begin
                we_nxt_s    = 1'b0;
                waddr_nxt_s = 5'd0;
                wdata_nxt_s = 32'd0;
                pc_nxt_s    = 32'd0;
            end
        endcase

        ready_nxt_s = (state_nxt_s == ST_IDLE) | (state_nxt_s == ST_S2) |
                      (state_nxt_s == ST_BUB) |
                      ((state_nxt_s == ST_S1) & ~buf_w2_nxt_s);

        // The entry being written stays pending for the whole write cycle
        fwd_nxt_s = pack_fwd(state_nxt_s != ST_IDLE,
                             buf_w1_nxt_s & (state_nxt_s == ST_S1),
                             buf_i1_dest_nxt_s, buf_i1_wdata_nxt_s,
                             buf_w2_nxt_s & ((state_nxt_s == ST_S1) |
                                             (state_nxt_s == ST_S2)),
                             buf_i2_dest_nxt_s, buf_i2_wdata_nxt_s);
    end

    // State and bundle buffer; reset drops any in-flight bundle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r        <= ST_IDLE;
            buf_w1_r       <= 1'b0;
            buf_i1_dest_r  <= 5'd0;
            buf_i1_wdata_r <= 32'd0;
            buf_i1_pc_r    <= '0;
            buf_w2_r       <= 1'b0;
            buf_i2_dest_r  <= 5'd0;
            buf_i2_wdata_r <= 32'd0;
            buf_i2_pc_r    <= '0;
        end else begin
            state_r        <= state_nxt_s;
            buf_w1_r       <= buf_w1_nxt_s;
            buf_i1_dest_r  <= buf_i1_dest_nxt_s;
            buf_i1_wdata_r <= buf_i1_wdata_nxt_s;
            buf_i1_pc_r    <= buf_i1_pc_nxt_s;
            buf_w2_r       <= buf_w2_nxt_s;
            buf_i2_dest_r  <= buf_i2_dest_nxt_s;
            buf_i2_wdata_r <= buf_i2_wdata_nxt_s;
            buf_i2_pc_r    <= buf_i2_pc_nxt_s;
        end
    end

    // Registered RF write, trace, ready and forward outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            in_ready          <= 1'b1;
            rf_we             <= 1'b0;
            rf_waddr          <= 5'd0;
            rf_wdata          <= 32'd0;
            fwd_bus           <= '0;
            debug_wb_pc       <= 32'd0;
            debug_wb_rf_wen   <= 4'd0;
            debug_wb_rf_wnum  <= 5'd0;
            debug_wb_rf_wdata <= 32'd0;
        end else begin
            in_ready          <= ready_nxt_s;
            rf_we             <= we_nxt_s;
            rf_waddr          <= waddr_nxt_s;
            rf_wdata          <= wdata_nxt_s;
            fwd_bus           <= fwd_nxt_s;
            debug_wb_pc       <= pc_nxt_s;
            debug_wb_rf_wen   <= {4{we_nxt_s}};
            debug_wb_rf_wnum  <= waddr_nxt_s;
            debug_wb_rf_wdata <= wdata_nxt_s;
        end
    end

endmodule

// File: tb/tb_wb_rf_write_sched.sv
// Bench for wb_rf_write_sched: two instances (DROP_R0=1 and DROP_R0=0)
// share the input bus. A per-instance queue of cycle slots, built from the
// bundle rules, predicts every output on every cycle.
module tb_wb_rf_write_sched;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_i1_we;
    logic [4:0]  in_i1_dest;
    logic [31:0] in_i1_wdata;
    logic [31:0] in_i1_pc;
    logic        in_i2_valid;
    logic        in_i2_we;
    logic [4:0]  in_i2_dest;
    logic [31:0] in_i2_wdata;
    logic [31:0] in_i2_pc;

    logic        a_rdy, a_we;  logic [4:0] a_wa; logic [31:0] a_wd; logic [76:0] a_fwd;
    logic [31:0] a_pc; logic [3:0] a_wen; logic [4:0] a_wnum; logic [31:0] a_dwd;
    logic        b_rdy, b_we;  logic [4:0] b_wa; logic [31:0] b_wd; logic [76:0] b_fwd;
    logic [31:0] b_pc; logic [3:0] b_wen; logic [4:0] b_wnum; logic [31:0] b_dwd;

    always #5 clk = ~clk;

    wb_rf_write_sched #(.DROP_R0(1'b1), .PC_W(32)) u_dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(a_rdy),
        .in_i1_we(in_i1_we), .in_i1_dest(in_i1_dest), .in_i1_wdata(in_i1_wdata),
        .in_i1_pc(in_i1_pc), .in_i2_valid(in_i2_valid), .in_i2_we(in_i2_we),
        .in_i2_dest(in_i2_dest), .in_i2_wdata(in_i2_wdata), .in_i2_pc(in_i2_pc),
        .rf_we(a_we), .rf_waddr(a_wa), .rf_wdata(a_wd), .fwd_bus(a_fwd),
        .debug_wb_pc(a_pc), .debug_wb_rf_wen(a_wen), .debug_wb_rf_wnum(a_wnum),
        .debug_wb_rf_wdata(a_dwd));

    wb_rf_write_sched #(.DROP_R0(1'b0), .PC_W(32)) u_dut_keep_r0 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(b_rdy),
        .in_i1_we(in_i1_we), .in_i1_dest(in_i1_dest), .in_i1_wdata(in_i1_wdata),
        .in_i1_pc(in_i1_pc), .in_i2_valid(in_i2_valid), .in_i2_we(in_i2_we),
        .in_i2_dest(in_i2_dest), .in_i2_wdata(in_i2_wdata), .in_i2_pc(in_i2_pc),
        .rf_we(b_we), .rf_waddr(b_wa), .rf_wdata(b_wd), .fwd_bus(b_fwd),
        .debug_wb_pc(b_pc), .debug_wb_rf_wen(b_wen), .debug_wb_rf_wnum(b_wnum),
        .debug_wb_rf_wdata(b_dwd));

    typedef struct {
        bit          we;
        bit          is_i2;
        logic [4:0]  dest;
        logic [31:0] data;
        logic [31:0] pc;
    } slot_t;

    typedef struct {
        bit i1_we; logic [4:0] d1; logic [31:0] x1; logic [31:0] p1;
        bit i2v; bit i2_we; logic [4:0] d2; logic [31:0] x2; logic [31:0] p2;
    } bundle_t;

    slot_t       qa[$];
    slot_t       qb[$];
    logic [31:0] model_rf [32];
    logic [31:0] dut_rf [32];
    int          n_vec = 0;
    int          n_err = 0;
    int          wr_cnt = 0;
    int          cyc_cnt = 0;

    task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic bundle_t mk(bit i1we, logic [4:0] d1, logic [31:0] x1, logic [31:0] p1,
                                   bit i2v, bit i2we, logic [4:0] d2, logic [31:0] x2,
                                   logic [31:0] p2);
        bundle_t b;
        b.i1_we = i1we; b.d1 = d1; b.x1 = x1; b.p1 = p1;
        b.i2v = i2v; b.i2_we = i2we; b.d2 = d2; b.x2 = x2; b.p2 = p2;
        return b;
    endfunction

    // Cycle slots a bundle occupies: one per real write, else a single bubble
    function automatic void add(input bit drop, input bundle_t b);
        slot_t s;
        bit w1, w2;
        int n;
        w1 = b.i1_we && !(drop && b.d1 == 5'd0);
        w2 = b.i2v && b.i2_we && !(drop && b.d2 == 5'd0);
        n = 0;
        if (w1) begin
            s.we = 1'b1; s.is_i2 = 1'b0; s.dest = b.d1; s.data = b.x1; s.pc = b.p1;
            if (drop) qa.push_back(s); else qb.push_back(s);
            n++;
        end
        if (w2) begin
            s.we = 1'b1; s.is_i2 = 1'b1; s.dest = b.d2; s.data = b.x2; s.pc = b.p2;
            if (drop) qa.push_back(s); else qb.push_back(s);
            n++;
        end
        if (n == 0) begin
            s.we = 1'b0; s.is_i2 = 1'b0; s.dest = 5'd0; s.data = 32'd0; s.pc = 32'd0;
            if (drop) qa.push_back(s); else qb.push_back(s);
        end
    endfunction

    task automatic check_one(input string nm, input bit drop,
                             input logic we, input logic [4:0] wa, input logic [31:0] wd,
                             input logic [31:0] pc, input logic [3:0] wen,
                             input logic [4:0] wnum, input logic [31:0] dwd,
                             input logic rdy, input logic [76:0] fwd);
        slot_t q[$];
        logic [37:0] e_rf;
        logic [72:0] e_dbg;
        logic busy, p1, p2;
        logic [4:0] d1, d2;
        logic [31:0] x1, x2;
        q = drop ? qa : qb;
        e_rf = 38'd0; e_dbg = 73'd0;
        if (q.size() > 0 && q[0].we) begin
            e_rf  = {1'b1, q[0].dest, q[0].data};
            e_dbg = {q[0].pc, 4'hF, q[0].dest, q[0].data};
        end
        busy = (q.size() > 0);
        p1 = 1'b0; p2 = 1'b0; d1 = 5'd0; d2 = 5'd0; x1 = 32'd0; x2 = 32'd0;
        foreach (q[k]) begin
            if (q[k].we && !q[k].is_i2) begin p1 = 1'b1; d1 = q[k].dest; x1 = q[k].data; end
            if (q[k].we &&  q[k].is_i2) begin p2 = 1'b1; d2 = q[k].dest; x2 = q[k].data; end
        end
        chk({nm, "_rf"},    {we, wa, wd}, e_rf);
        chk({nm, "_trace"}, {pc, wen, wnum, dwd}, e_dbg);
        chk({nm, "_ready"}, rdy, (q.size() <= 1));
        chk({nm, "_fwd"},   fwd, {busy, p1, d1, x1, p2, d2, x2});
    endtask

    task automatic sample();
        check_one("drop", 1'b1, a_we, a_wa, a_wd, a_pc, a_wen, a_wnum, a_dwd, a_rdy, a_fwd);
        check_one("keep", 1'b0, b_we, b_wa, b_wd, b_pc, b_wen, b_wnum, b_dwd, b_rdy, b_fwd);
        if (a_we === 1'b1) begin dut_rf[a_wa] = a_wd; wr_cnt++; end
        if (qa.size() > 0 && qa[0].we) model_rf[qa[0].dest] = qa[0].data;
    endtask

    // One clock: drive at negedge, advance model at posedge, check at negedge
    task automatic cycle(input bit v, input bundle_t b, output bit acc);
        bit ra, rb;
        in_valid = v;
        in_i1_we = b.i1_we; in_i1_dest = b.d1; in_i1_wdata = b.x1; in_i1_pc = b.p1;
        in_i2_valid = b.i2v; in_i2_we = b.i2_we; in_i2_dest = b.d2;
        in_i2_wdata = b.x2; in_i2_pc = b.p2;
        ra = (qa.size() <= 1);
        rb = (qb.size() <= 1);
        acc = v && ra;
        @(posedge clk);
        if (qa.size() > 0) void'(qa.pop_front());
        if (qb.size() > 0) void'(qb.pop_front());
        if (v && ra) add(1'b1, b);
        if (v && rb) add(1'b0, b);
        cyc_cnt++;
        @(negedge clk);
        sample();
    endtask

    // Offer a bundle until accepted; 'hold' keeps in_valid high while waiting
    task automatic offer(input bundle_t b, input bit hold);
        bit acc;
        bit v;
        for (int i = 0; i < 8; i++) begin
            v = hold || (qa.size() <= 1 && qb.size() <= 1);
            cycle(v, b, acc);
            if (acc) return;
        end
        chk("offer_timeout", 1'b0, 1'b1);
    endtask

    task automatic idle(input int n);
        bit acc;
        bundle_t z;
        z = mk(1'b0, 5'd0, 32'd0, 32'd0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0);
        for (int i = 0; i < n; i++) cycle(1'b0, z, acc);
    endtask

    initial begin
        bundle_t b;
        int w0, c0;
        for (int r = 0; r < 32; r++) begin model_rf[r] = 32'd0; dut_rf[r] = 32'd0; end
        reset = 1'b1;
        b = mk(1'b0, 5'd0, 32'd0, 32'd0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0);
        in_valid = 1'b0;
        in_i1_we = 1'b0; in_i1_dest = 5'd0; in_i1_wdata = 32'd0; in_i1_pc = 32'd0;
        in_i2_valid = 1'b0; in_i2_we = 1'b0; in_i2_dest = 5'd0;
        in_i2_wdata = 32'd0; in_i2_pc = 32'd0;
        @(negedge clk);
        sample();
        reset = 1'b0;
        idle(2);

        // 1: single write
        offer(mk(1'b1, 5'd3, 32'h11, 32'hbfc00000, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0), 1'b0);
        chk("t1_write", {a_we, a_wa, a_wd, a_pc}, {1'b1, 5'd3, 32'h11, 32'hbfc00000});
        chk("t1_ready", a_rdy, 1'b1);
        idle(2);

        // 2: two writes, second uses inst2 pc
        offer(mk(1'b1, 5'd4, 32'hA, 32'hbfc00010, 1'b1, 1'b1, 5'd5, 32'hB, 32'hbfc00014), 1'b0);
        chk("t2_first", {a_we, a_wa, a_rdy}, {1'b1, 5'd4, 1'b0});
        idle(1);
        chk("t2_second", {a_we, a_wa, a_pc, a_rdy}, {1'b1, 5'd5, 32'hbfc00014, 1'b1});
        idle(2);

        // 3: same destination, inst2 lands last
        offer(mk(1'b1, 5'd7, 32'h1, 32'h100, 1'b1, 1'b1, 5'd7, 32'h2, 32'h104), 1'b0);
        idle(3);
        chk("t3_rf7", dut_rf[7], 32'h2);

        // 4: $0 dropped on one instance, kept on the other
        offer(mk(1'b1, 5'd0, 32'hFF, 32'h200, 1'b1, 1'b1, 5'd6, 32'h9, 32'h204), 1'b0);
        chk("t4_drop_first", {a_we, a_wa, a_wd}, {1'b1, 5'd6, 32'h9});
        chk("t4_keep_first", {b_we, b_wa, b_wd}, {1'b1, 5'd0, 32'hFF});
        idle(3);

        // 5: four double-write bundles with in_valid held high
        w0 = wr_cnt;
        c0 = cyc_cnt;
        for (int k = 0; k < 4; k++)
            offer(mk(1'b1, 5'(8 + 2 * k), 32'(k), 32'(16 * k),
                     1'b1, 1'b1, 5'(9 + 2 * k), 32'(k + 100), 32'(16 * k + 4)), 1'b1);
        chk("t5_accept_span", cyc_cnt - c0, 7);
        idle(3);
        chk("t5_writes", wr_cnt - w0, 8);

        // 6: reset in S1 of a double-write bundle
        offer(mk(1'b1, 5'd12, 32'h55, 32'h300, 1'b1, 1'b1, 5'd13, 32'h66, 32'h304), 1'b0);
        reset = 1'b1;
        #1;
        qa.delete();
        qb.delete();
        chk("t6_rst_out", {a_we, a_fwd, a_rdy}, {1'b0, 77'd0, 1'b1});
        @(negedge clk);
        sample();
        reset = 1'b0;
        idle(3);

        // Randomized bundles
        for (int n = 0; n < 300; n++) begin
            b.i1_we = 1'($urandom_range(0, 3) != 0);
            b.d1    = ($urandom_range(0, 4) == 0) ? 5'd0 : 5'($urandom);
            b.x1    = $urandom;
            b.p1    = $urandom;
            b.i2v   = 1'($urandom_range(0, 1));
            b.i2_we = 1'($urandom_range(0, 3) != 0);
            b.d2    = ($urandom_range(0, 3) == 0) ? b.d1 :
                      (($urandom_range(0, 4) == 0) ? 5'd0 : 5'($urandom));
            b.x2    = $urandom;
            b.p2    = $urandom;
            offer(b, 1'b0);
            if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 2));
        end
        idle(3);
        for (int r = 1; r < 32; r++) chk("final_rf", dut_rf[r], model_rf[r]);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
